// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default widths, per-layer feature-map
// sizes, the up-sampler row-state type and small sizing helpers.
package cnn_pkg;

  localparam int unsigned CNN_BW          = 16;
  localparam int unsigned UNPOOL1_IF_SIZE = 28;

  // Live row (pixels arriving) versus replay row (pixels read back).
  typedef enum logic {
    ROW_A,
    ROW_B
  } unpool_state_e;

  // Edge length of the pooled map feeding an up-sampler of output edge if_size.
  function automatic int unsigned pooled_edge(input int unsigned if_size);
    return if_size / 2;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unpool_linebuf.sv
// One pooled row of pixels: single write port, asynchronous read port.
// Contents are never cleared; every entry is written before it is read.
module unpool_linebuf
  import cnn_pkg::*;
#(
  parameter int unsigned BW    = CNN_BW,
  parameter int unsigned DEPTH = 14,
  parameter int unsigned AW    = cnt_width(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [AW-1:0]        waddr_i,
  input  logic signed [BW-1:0] wdata_i,
  input  logic [AW-1:0]        raddr_i,
  output logic signed [BW-1:0] rdata_o
);

  logic signed [BW-1:0] mem_q [DEPTH];

  // Capture the live-row pixel at its column.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Replay read of the addressed column.
  always_comb begin
    rdata_o = mem_q[raddr_i];
  end

endmodule

// File: rtl/unpool1.sv
// 2x2 nearest-neighbour up-sampler. Each pooled pixel is emitted twice on
// the live row and stored; the stored row is then replayed twice per pixel.
module unpool1
  import cnn_pkg::*;
#(
  parameter int unsigned BW      = CNN_BW,
  parameter int unsigned P_SIZE  = 2,
  parameter int unsigned IF_SIZE = UNPOOL1_IF_SIZE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [BW-1:0] i_data,
  input  logic                 i_valid,
  output logic                 o_ready,
  output logic signed [BW-1:0] o_data,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic                 o_end
);

  localparam int unsigned PW = pooled_edge(IF_SIZE);
  localparam int unsigned CW = cnt_width(PW);
  localparam logic [CW-1:0] LAST = CW'(PW - 1);

  if (P_SIZE != 2 || (IF_SIZE % 2) != 0 || IF_SIZE < 2) begin : g_bad_params
    $error("unpool1: P_SIZE must be 2 and IF_SIZE even and >= 2");
  end

  unpool_state_e        state_q, state_d;
  logic                 ph_q, ph_d;
  logic [CW-1:0]        col_q, col_d;
  logic [CW-1:0]        row_q, row_d;
  logic signed [BW-1:0] odata_q, odata_d;
  logic signed [BW-1:0] rpix_q, rpix_d;
  logic                 ovalid_q, ovalid_d;
  logic                 oend_q, oend_d;
  logic                 last_q, last_d;
  logic                 adv;
  logic                 lb_we;
  logic signed [BW-1:0] lb_rdata;

  unpool_linebuf #(
    .BW    (BW),
    .DEPTH (PW),
    .AW    (CW)
  ) u_linebuf (
    .clk     (clk),
    .we_i    (lb_we),
    .waddr_i (col_q),
    .wdata_i (i_data),
    .raddr_i (col_q),
    .rdata_o (lb_rdata)
  );

  assign adv = !ovalid_q || i_ready;

  // Next-state, output register load and input handshake.
  // o_end needs the final pixel actually transferred, so the final replay beat
  // only arms last_q; the pulse follows the handshake that drains it.
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    col_d    = col_q;
    row_d    = row_q;
    odata_d  = odata_q;
    rpix_d   = rpix_q;
    ovalid_d = ovalid_q;
    oend_d   = ovalid_q && i_ready && last_q;
    last_d   = last_q && !(ovalid_q && i_ready);
    lb_we    = 1'b0;
    o_ready  = 1'b0;
    unique case (state_q)
      ROW_A: begin
        if (!ph_q) begin
          o_ready = adv && !rst;
          if (i_valid && adv) begin
            odata_d  = i_data;
            ovalid_d = 1'b1;
            rpix_d   = i_data;
            lb_we    = 1'b1;
            ph_d     = 1'b1;
          end else if (adv) begin
            ovalid_d = 1'b0;
          end
        end else if (adv) begin
          odata_d  = rpix_q;
          ovalid_d = 1'b1;
          ph_d     = 1'b0;
          if (col_q == LAST) begin
            col_d   = '0;
            state_d = ROW_B;
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      ROW_B: begin
        if (adv) begin
          odata_d  = lb_rdata;
          ovalid_d = 1'b1;
          ph_d     = !ph_q;
          if (ph_q) begin
            if (col_q == LAST) begin
              col_d   = '0;
              state_d = ROW_A;
              if (row_q == LAST) begin
                row_d  = '0;
                last_d = 1'b1;
              end else begin
                row_d = row_q + CW'(1);
              end
            end else begin
              col_d = col_q + CW'(1);
            end
          end
        end
      end
      default: state_d = ROW_A;
    endcase
  end

  // State, counters and output register with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ROW_A;
      ph_q     <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      odata_q  <= '0;
      rpix_q   <= '0;
      ovalid_q <= 1'b0;
      oend_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      col_q    <= col_d;
      row_q    <= row_d;
      odata_q  <= odata_d;
      rpix_q   <= rpix_d;
      ovalid_q <= ovalid_d;
      oend_q   <= oend_d;
      last_q   <= last_d;
    end
  end

  assign o_data  = odata_q;
  assign o_valid = ovalid_q;
  assign o_end   = oend_q;

endmodule

// File: tb/tb_unpool1.sv
// Bench for unpool1: instance 0 at IF_SIZE=4, instance 1 at IF_SIZE=28.
// The model expands each pooled frame into its up-sampled raster and every
// output transfer is checked against it; literal tables pin key sequences.
module tb_unpool1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic signed [15:0] i_data  [2];
  logic signed [15:0] o_data  [2];
  logic               i_valid [2];
  logic               o_ready [2];
  logic               o_valid [2];
  logic               i_ready [2];
  logic               o_end   [2];

  always #5 clk = ~clk;

  unpool1 #(.BW(16), .P_SIZE(2), .IF_SIZE(4)) u4 (
    .clk(clk), .rst(rst), .i_data(i_data[0]), .i_valid(i_valid[0]), .o_ready(o_ready[0]),
    .o_data(o_data[0]), .o_valid(o_valid[0]), .i_ready(i_ready[0]), .o_end(o_end[0]));

  unpool1 #(.BW(16), .P_SIZE(2), .IF_SIZE(28)) u28 (
    .clk(clk), .rst(rst), .i_data(i_data[1]), .i_valid(i_valid[1]), .o_ready(o_ready[1]),
    .o_data(o_data[1]), .o_valid(o_valid[1]), .i_ready(i_ready[1]), .o_end(o_end[1]));

  int n_vec = 0;
  int n_err = 0;

  int in_mem  [2][0:1023];
  int in_hd   [2];
  int in_tl   [2];
  int exp_mem [2][0:2047];
  int exp_hd  [2];
  int exp_tl  [2];
  int cap     [2][0:2047];
  int cap_n   [2];
  int out_idx [2];
  bit end_pend[2];
  bit hold_v  [2];
  int hold_d  [2];
  int wait_cur[2];
  int waits   [2][0:1023];
  int acc_cnt [2];
  int rdy_mode[2];
  int end_cnt [2];
  bit rdy_s   [2];
  int frame_pix [0:195];

  function automatic int fedge(input int k);
    return (k == 0) ? 4 : 28;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the pooled frame as stimulus and its up-sampled raster as expectation.
  task automatic push_frame(input int k);
    int pw;
    pw = fedge(k) / 2;
    for (int i = 0; i < pw * pw; i++) begin
      in_mem[k][in_tl[k]] = frame_pix[i];
      in_tl[k]++;
    end
    for (int y = 0; y < 2 * pw; y++)
      for (int x = 0; x < 2 * pw; x++) begin
        exp_mem[k][exp_tl[k]] = frame_pix[(y / 2) * pw + (x / 2)];
        exp_tl[k]++;
      end
  endtask

  // One clock: check and account at the falling edge, drive after the rising edge.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        chk("rst_o_valid", int'(o_valid[k]), 0);
        chk("rst_o_end", int'(o_end[k]), 0);
        chk("rst_o_data", int'(o_data[k]), 0);
        chk("rst_o_ready", int'(o_ready[k]), 0);
        out_idx[k] = 0; end_pend[k] = 1'b0; hold_v[k] = 1'b0; wait_cur[k] = 0;
      end else begin
        chk($sformatf("o_end%0d", k), int'(o_end[k]), int'(end_pend[k]));
        if (o_end[k]) end_cnt[k]++;
        if (hold_v[k]) begin
          chk($sformatf("hold_valid%0d", k), int'(o_valid[k]), 1);
          chk($sformatf("hold_data%0d", k), int'(o_data[k]), hold_d[k]);
        end
        end_pend[k] = 1'b0;
        if (o_valid[k] && i_ready[k]) begin
          cap[k][cap_n[k]] = int'(o_data[k]);
          cap_n[k]++;
          if (exp_hd[k] < exp_tl[k]) begin
            chk($sformatf("data%0d[%0d]", k, out_idx[k]), int'(o_data[k]), exp_mem[k][exp_hd[k]]);
            exp_hd[k]++;
          end else begin
            n_vec++; n_err++;
            $display("FAIL spurious%0d: got output %0d, required none", k, int'(o_data[k]));
          end
          out_idx[k]++;
          if (out_idx[k] == fedge(k) * fedge(k)) begin
            out_idx[k] = 0;
            end_pend[k] = 1'b1;
          end
        end
        hold_v[k] = o_valid[k] && !i_ready[k];
        hold_d[k] = int'(o_data[k]);
        if (i_valid[k]) begin
          if (o_ready[k]) begin
            waits[k][acc_cnt[k]] = wait_cur[k];
            acc_cnt[k]++;
            in_hd[k]++;
            wait_cur[k] = 0;
          end else begin
            wait_cur[k]++;
          end
        end
      end
      rdy_s[k] = o_ready[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      case (rdy_mode[k])
        1:       i_ready[k] = !i_ready[k];
        2:       i_ready[k] = 1'($urandom_range(0, 1));
        default: i_ready[k] = 1'b1;
      endcase
      i_valid[k] = in_hd[k] < in_tl[k];
      i_data[k]  = i_valid[k] ? 16'(in_mem[k][in_hd[k]]) : 16'($urandom);
    end
  endtask

  task automatic drain(input int k, input int budget);
    int c;
    c = 0;
    while ((in_hd[k] < in_tl[k] || exp_hd[k] < exp_tl[k]) && c < budget) begin
      tick();
      c++;
    end
    if (c >= budget) begin
      n_vec++; n_err++;
      $display("FAIL drain%0d: %0d outputs outstanding after %0d cycles, required 0",
               k, exp_tl[k] - exp_hd[k], budget);
    end
    tick();
    tick();
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_hd[k] = in_tl[k]; exp_hd[k] = exp_tl[k]; i_valid[k] = 1'b0;
    end
    for (int i = 0; i < cycles; i++) tick();
    rst = 1'b0;
  endtask

  task automatic chk_cap(input string name, input int exp[16]);
    chk({name, "_count"}, cap_n[0], 16);
    for (int i = 0; i < 16; i++) chk($sformatf("%s[%0d]", name, i), cap[0][i], exp[i]);
  endtask

  task automatic set4(input int a, input int b, input int c, input int d);
    frame_pix[0] = a; frame_pix[1] = b; frame_pix[2] = c; frame_pix[3] = d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int e0;
    for (int k = 0; k < 2; k++) begin
      in_hd[k] = 0; in_tl[k] = 0; exp_hd[k] = 0; exp_tl[k] = 0; cap_n[k] = 0;
      out_idx[k] = 0; end_pend[k] = 1'b0; hold_v[k] = 1'b0; wait_cur[k] = 0;
      acc_cnt[k] = 0; rdy_mode[k] = 0; end_cnt[k] = 0;
      i_valid[k] = 1'b0; i_data[k] = '0; i_ready[k] = 1'b1;
    end

    // 1: reset held, then released
    rst = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    tick();
    chk("ready_after_rst0", int'(rdy_s[0]), 1);
    chk("ready_after_rst1", int'(rdy_s[1]), 1);

    // 2: continuous 1,2,3,4
    cap_n[0] = 0; e0 = end_cnt[0];
    set4(1, 2, 3, 4); push_frame(0);
    drain(0, 200);
    chk_cap("t2", '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4});
    chk("t2_end_pulses", end_cnt[0] - e0, 1);

    // 3: signed extremes
    cap_n[0] = 0;
    set4(-5, 7, -32768, 32767); push_frame(0);
    drain(0, 200);
    chk_cap("t3", '{-5,-5,7,7, -5,-5,7,7, -32768,-32768,32767,32767, -32768,-32768,32767,32767});

    // 4: i_ready toggling
    cap_n[0] = 0; rdy_mode[0] = 1;
    set4(1, 2, 3, 4); push_frame(0);
    drain(0, 400);
    rdy_mode[0] = 0;
    chk_cap("t4", '{1,1,2,2, 1,1,2,2, 3,3,4,4, 3,3,4,4});

    // 5: pixel 3 presented during the replay row must wait for the next live row
    cap_n[0] = 0; base = acc_cnt[0];
    set4(10, 20, 30, 40); push_frame(0);
    drain(0, 200);
    chk("t5_wait_p0", waits[0][base + 0], 0);
    chk("t5_wait_p1", waits[0][base + 1], 1);
    chk("t5_wait_p2", waits[0][base + 2], 5);
    chk("t5_wait_p3", waits[0][base + 3], 1);
    chk_cap("t5", '{10,10,20,20, 10,10,20,20, 30,30,40,40, 30,30,40,40});

    // 6: abort after five outputs, then a full frame
    cap_n[0] = 0; e0 = end_cnt[0];
    set4(1, 2, 3, 4); push_frame(0);
    begin
      int c;
      c = 0;
      while (cap_n[0] < 5 && c < 50) begin
        tick();
        c++;
      end
      if (c >= 50) begin
        n_vec++; n_err++;
        $display("FAIL t6_abort_wait: %0d outputs seen, required 5", cap_n[0]);
      end
    end
    do_reset(2);
    cap_n[0] = 0;
    set4(9, 8, 7, 6); push_frame(0);
    drain(0, 200);
    chk_cap("t6", '{9,9,8,8, 9,9,8,8, 7,7,6,6, 7,7,6,6});
    chk("t6_end_pulses", end_cnt[0] - e0, 1);

    // 7: IF_SIZE=28 ramp frame with random back-pressure
    cap_n[1] = 0; e0 = end_cnt[1]; rdy_mode[1] = 2;
    for (int i = 0; i < 196; i++) frame_pix[i] = i * 331 - 32000;
    push_frame(1);
    drain(1, 5000);
    rdy_mode[1] = 0;
    chk("t7_count", cap_n[1], 784);
    chk("t7_first", cap[1][0], -32000);
    chk("t7_row1_col3", cap[1][28 + 3], -31669);
    chk("t7_last", cap[1][783], 195 * 331 - 32000);
    chk("t7_end_pulses", end_cnt[1] - e0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
